face_spi_driver: RTL and testbench
==================================

// Module: face_spi_driver
// PURPOSE
//   Renders the pet's 4-bit mood state as an 8x8 face on a MAX7219 LED matrix over SPI.
//   Sits directly downstream of the main pet state logic and consumes its `state` code.
//   Runs the MAX7219 init sequence, then writes 8 row registers per render pass.
//   Re-renders on a state change and on a periodic refresh.
// PARAMETERS
//   CLK_DIV         25         clk cycles per SCLK half-period (1 MHz SCLK at 50 MHz clk); >=1
//   INTENSITY       4'h8       MAX7219 intensity register value
//   CS_GAP          4          clk cycles CS held high between frames; >=1
//   REFRESH_CYCLES  5_000_000  clk cycles between forced re-renders (100 ms)
// PORTS
//   clk         in   1  system clock, 50 MHz
//   reset       in   1  synchronous, active-high
//   state       in   4  mood code: 0 neutral, 1 hungry, 2 happy, 3 eating, 4..15 invalid
//   mosi        out  1  SPI data, MSB first
//   sclk        out  1  SPI clock, mode 0 (idle low, sample on rising edge)
//   cs          out  1  MAX7219 LOAD/CS, active low
//   busy        out  1  high while any frame or gap is in progress
//   frame_done  out  1  one-cycle pulse when CS rises after the row-8 frame
// BEHAVIOUR
//   Clocking and reset: one clock. Reset is synchronous, active-high.
//   Reset values: cs=1, sclk=0, mosi=0, busy=0, frame_done=0, seq_idx=0, init_done=0.
//     Reset asserted mid-frame aborts that frame on the next edge; CS returns high.
//   Frame (16 bit = {addr[7:0], data[7:0]}):
//     LOAD: cs<=0, mosi<=bit15.
//     Every CLK_DIV cycles, sclk toggles; 32 toggles total.
//     mosi updates to the next bit on each falling edge.
//     After the 32nd toggle, sclk stays low for a further CLK_DIV cycles, then cs<=1.
//     CS is low for exactly 33*CLK_DIV cycles.
//     CS then stays high for CS_GAP cycles (GAP) before the next frame.
//   FSM states and transitions:
//     IDLE -> LOAD when a pass is requested.
//     LOAD -> SHIFT after 1 cycle.
//     SHIFT -> HOLD after 32 toggles.
//     HOLD -> GAP after CLK_DIV cycles.
//     GAP -> LOAD if frames remain in the pass; GAP -> IDLE otherwise.
//   Sequence, indexed by seq_idx:
//     0..4: 0x0900 (no decode), {0x0A,4'h0,INTENSITY}, 0x0B07 (scan all), 0x0F00 (test off), 0x0C01 (run).
//     5..12: {row 1..8, glyph[face_q][row]}.
//   Init runs once after reset release. The first LOAD occurs on the first cycle with reset low.
//     After init_done=1, passes start at seq_idx=5.
//   face_q <= state, sampled on the LOAD cycle of seq_idx 5. A pass is never torn.
//   pending flag: set when state != face_q while busy, or when the refresh counter expires.
//     When set, a new pass starts immediately after the current pass's GAP; pending then clears.
//     At most one queued pass: further events while pending=1 are absorbed.
//   Refresh counter: counts in IDLE and resets whenever a pass starts.
//     Reaching REFRESH_CYCLES-1 requests a pass.
//   Simultaneous state change and refresh expiry: a single pass.
//   A state change in IDLE starts a pass on the next cycle.
//   Invalid state codes 4..15 render the X glyph: 81 42 24 18 18 24 42 81.
//   busy=1 from LOAD through the final GAP cycle of a pass.
//     frame_done rises together with the final cs 0->1 edge.
// STRUCTURE
//   Shared header face_defs.vh:
//     MAX7219 register addresses (0x01..0x08, 0x09, 0x0A, 0x0B, 0x0C, 0x0F).
//     Mood state codes.
//     8x8 glyph ROM: a function of (face, row) returning 8 bits.
//   Sub-module spi16_tx: 16-bit mode-0 frame shifter with start/done, carrying CLK_DIV and CS_GAP.
//     The top module holds the sequencer, state latch, pending flag and refresh timer.
// TESTING
//   (CLK_DIV=2, CS_GAP=4, REFRESH_CYCLES=2000 unless noted)
//   1. Release reset, state=0 -> 13 frames decoded from sampled MOSI:
//        0x0900 0x0A08 0x0B07 0x0F00 0x0C01 then 0x01xx..0x08xx matching the neutral glyph.
//      Each CS-low window = 66 cycles; frame_done pulses once; busy=0 afterwards.
//   2. Change state 0->1 during the row-3 frame -> rows 4..8 are still the neutral glyph.
//      A second pass of 8 row frames follows with the hungry glyph and no init frames.
//   3. Hold state constant -> a pass of 8 row frames every ~2000 idle cycles, no init frames.
//      Raise state 2 exactly on the refresh-expiry cycle -> one pass only.
//   4. state=9 -> rows 0x0181 0x0242 0x0324 0x0418 0x0518 0x0624 0x0742 0x0881.
//   5. Assert reset mid-SHIFT of row 5 -> next edge: cs=1, sclk=0, mosi=0, busy=0.
//      On release, the full 13-frame init pass repeats.
//   6. SPI timing checker on every frame: MOSI is stable across each SCLK rising edge.
//      Exactly 16 rising edges per CS-low window; SCLK=0 at both CS edges.

Source files
------------

// File: rtl/face_spi_driver_pkg.sv
// Shared definitions for the MAX7219 face renderer: register map, mood codes,
// the 8x8 glyph ROM and the init/row frame sequence.
package face_spi_driver_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_SHIFT,
    TX_HOLD,
    TX_GAP
  } tx_state_e;

  typedef enum logic [3:0] {
    MOOD_NEUTRAL = 4'd0,
    MOOD_HUNGRY  = 4'd1,
    MOOD_HAPPY   = 4'd2,
    MOOD_EATING  = 4'd3
  } mood_e;

  localparam logic [7:0] ADDR_DIGIT0     = 8'h01;
  localparam logic [7:0] ADDR_DECODE     = 8'h09;
  localparam logic [7:0] ADDR_INTENSITY  = 8'h0A;
  localparam logic [7:0] ADDR_SCAN_LIMIT = 8'h0B;
  localparam logic [7:0] ADDR_SHUTDOWN   = 8'h0C;
  localparam logic [7:0] ADDR_TEST       = 8'h0F;

  localparam logic [3:0] ROW_FIRST_IDX = 4'd5;
  localparam logic [3:0] SEQ_LAST_IDX  = 4'd12;

  // Top row in the most significant byte.
  localparam logic [63:0] GLYPH_NEUTRAL = 64'h3C42_A581_81BD_423C;
  localparam logic [63:0] GLYPH_HUNGRY  = 64'h3C42_A581_99A5_423C;
  localparam logic [63:0] GLYPH_HAPPY   = 64'h3C42_A581_A599_423C;
  localparam logic [63:0] GLYPH_EATING  = 64'h3C42_A581_BDBD_423C;
  localparam logic [63:0] GLYPH_X       = 64'h8142_2418_1824_4281;

  function automatic logic [7:0] glyph_row(input logic [3:0] face, input logic [2:0] row);
    logic [63:0] g;
    case (face)
      MOOD_NEUTRAL: g = GLYPH_NEUTRAL;
      MOOD_HUNGRY:  g = GLYPH_HUNGRY;
      MOOD_HAPPY:   g = GLYPH_HAPPY;
      MOOD_EATING:  g = GLYPH_EATING;
      default:      g = GLYPH_X;
    endcase
    return g[{~row, 3'b000} +: 8];
  endfunction

  function automatic logic [15:0] seq_word(input logic [3:0] idx, input logic [3:0] face,
                                           input logic [3:0] intensity);
    logic [15:0] w;
    case (idx)
      4'd0:    w = {ADDR_DECODE, 8'h00};
      4'd1:    w = {ADDR_INTENSITY, 4'h0, intensity};
      4'd2:    w = {ADDR_SCAN_LIMIT, 8'h07};
      4'd3:    w = {ADDR_TEST, 8'h00};
      4'd4:    w = {ADDR_SHUTDOWN, 8'h01};
      default: w = {ADDR_DIGIT0 + 8'(idx - ROW_FIRST_IDX), glyph_row(face, 3'(idx - ROW_FIRST_IDX))};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/face_spi_driver_spi16_tx.sv
// 16-bit SPI mode-0 frame shifter: CS low for 33 half-periods, then a CS-high gap.
// A new start is accepted while idle or on the last gap cycle for back-to-back frames.
module spi16_tx
  import face_spi_driver_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] data,
  output logic        cs,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_rise,
  output logic        gap_last
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

  tx_state_e   st_q, st_d;
  logic        cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  tog_q, tog_d;
  logic [14:0] shreg_q, shreg_d;
  logic        div_hit;

  always_comb begin
    st_d     = st_q;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    cnt_d    = cnt_q;
    tog_d    = tog_q;
    shreg_d  = shreg_q;
    div_hit  = (cnt_q == DIV_LAST);
    cs_rise  = (st_q == TX_HOLD) && div_hit;
    gap_last = (st_q == TX_GAP) && (cnt_q == GAP_LAST);

    case (st_q)
      // LOAD is the first cycle of the first half-period, so it counts like SHIFT.
      TX_LOAD, TX_SHIFT: begin
        st_d  = TX_SHIFT;
        cnt_d = cnt_q + 16'd1;
        if (div_hit) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          tog_d  = tog_q + 5'd1;
          if (sclk_q) begin
            mosi_d  = shreg_q[14];
            shreg_d = {shreg_q[13:0], 1'b0};
          end
          if (tog_q == 5'd31) st_d = TX_HOLD;
        end
      end
      TX_HOLD: begin
        cnt_d = cnt_q + 16'd1;
        if (div_hit) begin
          cnt_d = '0;
          cs_d  = 1'b1;
          st_d  = TX_GAP;
        end
      end
      TX_GAP: begin
        cnt_d = cnt_q + 16'd1;
        if (gap_last) begin
          cnt_d = '0;
          st_d  = TX_IDLE;
        end
      end
      default: ;
    endcase

    if (start && ((st_q == TX_IDLE) || gap_last)) begin
      st_d    = TX_LOAD;
      cs_d    = 1'b0;
      sclk_d  = 1'b0;
      mosi_d  = data[15];
      shreg_d = data[14:0];
      cnt_d   = '0;
      tog_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= TX_IDLE;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cnt_q   <= '0;
      tog_q   <= '0;
      shreg_q <= '0;
    end else begin
      st_q    <= st_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      shreg_q <= shreg_d;
    end
  end

  assign cs   = cs_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;

endmodule

// File: rtl/face_spi_driver.sv
// Renders the 4-bit mood state as an 8x8 face on a MAX7219: one init pass after
// reset, then 8-row passes on state change or periodic refresh.
module face_spi_driver
  import face_spi_driver_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 25,
  parameter logic [3:0]  INTENSITY      = 4'h8,
  parameter int unsigned CS_GAP         = 4,
  parameter int unsigned REFRESH_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] state,
  output logic       mosi,
  output logic       sclk,
  output logic       cs,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_CYCLES - 1);

  logic [3:0]  seq_idx_q, seq_idx_d, face_q, face_d, next_idx;
  logic        init_done_q, init_done_d, pending_q, pending_d;
  logic        busy_q, busy_d, frame_done_q, frame_done_d;
  logic [31:0] refresh_cnt_q, refresh_cnt_d;
  logic        change, refresh_hit, row_start;
  logic        tx_start, tx_cs_rise, tx_gap_last;
  logic [15:0] tx_data;

  always_comb begin
    change      = (state != face_q);
    refresh_hit = !busy_q && (refresh_cnt_q == REFRESH_LAST);
    tx_start    = 1'b0;
    next_idx    = seq_idx_q;
    busy_d      = busy_q;

    if (!busy_q) begin
      if (!init_done_q) begin
        tx_start = 1'b1;
        next_idx = 4'd0;
      end else if (change || refresh_hit) begin
        tx_start = 1'b1;
        next_idx = ROW_FIRST_IDX;
      end
    end else if (tx_gap_last) begin
      if (seq_idx_q != SEQ_LAST_IDX) begin
        tx_start = 1'b1;
        next_idx = seq_idx_q + 4'd1;
      end else if (pending_q || change) begin
        tx_start = 1'b1;
        next_idx = ROW_FIRST_IDX;
      end else begin
        busy_d = 1'b0;
      end
    end
    if (tx_start) busy_d = 1'b1;

    // The face is latched only when row 1 starts, so a pass never mixes glyphs;
    // changes during init frames are picked up by that latch instead of pending.
    row_start     = tx_start && (next_idx == ROW_FIRST_IDX);
    seq_idx_d     = next_idx;
    face_d        = row_start ? state : face_q;
    init_done_d   = init_done_q | row_start;
    pending_d     = row_start ? 1'b0
                  : (pending_q | (busy_q && (seq_idx_q >= ROW_FIRST_IDX) && change));
    refresh_cnt_d = (busy_q || tx_start) ? '0 : refresh_cnt_q + 32'd1;
    frame_done_d  = tx_cs_rise && (seq_idx_q == SEQ_LAST_IDX);
    tx_data       = seq_word(next_idx, face_d, INTENSITY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_idx_q     <= '0;
      face_q        <= '0;
      init_done_q   <= 1'b0;
      pending_q     <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      refresh_cnt_q <= '0;
    end else begin
      seq_idx_q     <= seq_idx_d;
      face_q        <= face_d;
      init_done_q   <= init_done_d;
      pending_q     <= pending_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      refresh_cnt_q <= refresh_cnt_d;
    end
  end

  spi16_tx #(
    .CLK_DIV(CLK_DIV),
    .CS_GAP (CS_GAP)
  ) u_tx (
    .clk     (clk),
    .reset   (reset),
    .start   (tx_start),
    .data    (tx_data),
    .cs      (cs),
    .sclk    (sclk),
    .mosi    (mosi),
    .cs_rise (tx_cs_rise),
    .gap_last(tx_gap_last)
  );

  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_face_spi_driver.sv
// Scoreboard bench: expected frames are queued as stimulus is applied and popped
// by a MOSI/CS decoder that also checks SPI timing on every frame.
module tb_face_spi_driver;

  localparam logic [63:0] G_NEUTRAL = 64'h3C42A58181BD423C;
  localparam logic [63:0] G_HUNGRY  = 64'h3C42A58199A5423C;
  localparam logic [63:0] G_HAPPY   = 64'h3C42A581A599423C;
  localparam logic [63:0] G_X       = 64'h8142241818244281;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] state = 4'd0;
  logic       mosi, sclk, cs, busy, frame_done;

  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [15:0] exp_q[$];

  int unsigned frames_rx = 0;
  int unsigned fd_cnt = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, in_frame = 1'b0;
  int unsigned low_cnt = 0, nbits = 0;
  logic [15:0] word = '0;

  face_spi_driver #(
    .CLK_DIV       (2),
    .INTENSITY     (4'h8),
    .CS_GAP        (4),
    .REFRESH_CYCLES(2000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .state     (state),
    .mosi      (mosi),
    .sclk      (sclk),
    .cs        (cs),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_init();
    exp_q.push_back(16'h0900);
    exp_q.push_back(16'h0A08);
    exp_q.push_back(16'h0B07);
    exp_q.push_back(16'h0F00);
    exp_q.push_back(16'h0C01);
  endtask

  task automatic push_rows(input logic [63:0] g, input int unsigned n);
    for (int r = 0; r < int'(n); r++) exp_q.push_back({8'(r + 1), g[8*(7-r) +: 8]});
  endtask

  task automatic wait_busy(input logic val, input int unsigned max, input string tag,
                           output int unsigned n);
    logic ok;
    ok = 1'b0;
    n = 0;
    while (!ok && n < max) begin
      @(negedge clk);
      n++;
      if (busy === val) ok = 1'b1;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_frames(input int unsigned target, input int unsigned max);
    int unsigned n;
    n = 0;
    while (frames_rx < target && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wait_frames", 32'(frames_rx >= target), 32'd1);
  endtask

  task automatic wait_cs_low(input int unsigned max);
    int unsigned n;
    n = 0;
    while (cs !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wait_cs_low", 32'(cs), 32'd0);
  endtask

  // Frame decoder and SPI timing monitor.
  always @(negedge clk) begin
    if (reset) begin
      in_frame = 1'b0;
    end else begin
      if (frame_done === 1'b1) fd_cnt++;
      if (prev_cs && !cs) begin
        chk("sclk_at_cs_fall", 32'(sclk), 32'd0);
        in_frame = 1'b1;
        low_cnt = 0;
        nbits = 0;
        word = '0;
      end
      if (!cs) begin
        low_cnt++;
        if (!prev_sclk && sclk) begin
          chk("mosi_stable_at_rise", 32'(mosi), 32'(prev_mosi));
          word = {word[14:0], mosi};
          nbits++;
        end
      end
      if (!prev_cs && cs && in_frame) begin
        in_frame = 1'b0;
        chk("sclk_at_cs_rise", 32'(sclk), 32'd0);
        chk("cs_low_cycles", low_cnt, 32'd66);
        chk("sclk_rises", nbits, 32'd16);
        chk("frame_done_on_row8", 32'(frame_done), 32'(word[15:8] == 8'h08));
        chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("frame_word", 32'(word), 32'(exp_q.pop_front()));
        frames_rx++;
      end
    end
    prev_cs   = cs;
    prev_sclk = sclk;
    prev_mosi = mosi;
  end

  initial begin
    int unsigned n, base, fd0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);

    // 1: init pass with neutral face
    push_init();
    push_rows(G_NEUTRAL, 8);
    fd0 = fd_cnt;
    reset = 1'b0;
    @(negedge clk);
    chk("first_load_cs", 32'(cs), 32'd0);
    chk("first_load_busy", 32'(busy), 32'd1);
    wait_busy(1'b0, 1500, "init_pass_end", n);
    chk("init_frames_drained", exp_q.size(), 32'd0);
    chk("init_frame_done_count", fd_cnt - fd0, 32'd1);

    // 2: state change during row-3 frame of a refresh pass
    push_rows(G_NEUTRAL, 8);
    push_rows(G_HUNGRY, 8);
    fd0 = fd_cnt;
    wait_busy(1'b1, 2500, "refresh_start_t2", n);
    chk("refresh_interval_t2", n, 32'd2000);
    base = frames_rx;
    wait_frames(base + 2, 400);
    wait_cs_low(20);
    repeat (10) @(negedge clk);
    state = 4'd1;
    wait_busy(1'b0, 2000, "t2_pass_end", n);
    chk("t2_frames_drained", exp_q.size(), 32'd0);
    chk("t2_frame_done_count", fd_cnt - fd0, 32'd2);

    // 3: periodic refresh, then a state change exactly on the expiry cycle
    push_rows(G_HUNGRY, 8);
    wait_busy(1'b1, 2500, "refresh_start_t3", n);
    chk("refresh_interval_t3", n, 32'd2000);
    wait_busy(1'b0, 1500, "t3_pass_end", n);
    chk("t3_frames_drained", exp_q.size(), 32'd0);
    repeat (1999) @(negedge clk);
    chk("busy_before_expiry", 32'(busy), 32'd0);
    state = 4'd2;
    push_rows(G_HAPPY, 8);
    fd0 = fd_cnt;
    @(negedge clk);
    chk("expiry_pass_start", 32'(busy), 32'd1);
    wait_busy(1'b0, 1500, "t3b_pass_end", n);
    repeat (200) @(negedge clk);
    chk("single_pass_idle", 32'(busy), 32'd0);
    chk("t3b_frames_drained", exp_q.size(), 32'd0);
    chk("t3b_frame_done_count", fd_cnt - fd0, 32'd1);

    // 4: invalid state renders X glyph; idle change starts a pass next cycle
    state = 4'd9;
    push_rows(G_X, 8);
    @(negedge clk);
    chk("idle_change_start", 32'(busy), 32'd1);
    wait_busy(1'b0, 1500, "t4_pass_end", n);
    chk("t4_frames_drained", exp_q.size(), 32'd0);

    // 5: reset mid-SHIFT of row 5, then the full init pass repeats
    state = 4'd0;
    push_rows(G_NEUTRAL, 4);
    base = frames_rx;
    wait_frames(base + 4, 600);
    wait_cs_low(20);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_cs", 32'(cs), 32'd1);
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_mosi", 32'(mosi), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_frames_drained", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    push_init();
    push_rows(G_NEUTRAL, 8);
    fd0 = fd_cnt;
    reset = 1'b0;
    @(negedge clk);
    chk("reinit_load_cs", 32'(cs), 32'd0);
    wait_busy(1'b0, 1500, "reinit_pass_end", n);
    chk("reinit_frames_drained", exp_q.size(), 32'd0);
    chk("reinit_frame_done_count", fd_cnt - fd0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
